// File: rtl/complex_div_pkg.sv
// Shared definitions for the complex arithmetic blocks: default Q-format widths,
// saturation constants and the complex divider FSM encoding.
package complex_div_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FRAC_W_DEF = 14;

  // Symmetric clamp: the negative limit is -(2^(W-1)-1), never the most negative code.
  localparam logic signed [DATA_W_DEF-1:0] CLAMP_POS_DEF = 16'sh7FFF;
  localparam logic signed [DATA_W_DEF-1:0] CLAMP_NEG_DEF = -16'sh7FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } cdiv_state_e;

endpackage

// File: rtl/complex_div_mag_step.sv
// One restoring-division iteration: trial subtract of the aligned divisor from
// the running remainder, producing one quotient bit.
module cdiv_mag_step #(
  parameter int W = 49
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  assign q_bit_o = (rem_i >= div_i);
  assign rem_o   = q_bit_o ? (rem_i - div_i) : rem_i;

endmodule

// File: rtl/complex_div.sv
// Fixed-point complex divider y = a*conj(b)/|b|^2, one quotient bit per cycle
// per component, constant DATA_W-cycle latency from accept to out_valid.
module complex_div
  import complex_div_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] ar,
  input  logic signed [DATA_W-1:0] ai,
  input  logic signed [DATA_W-1:0] br,
  input  logic signed [DATA_W-1:0] bi,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] yr,
  output logic signed [DATA_W-1:0] yi,
  output logic                     div_by_zero,
  output logic                     sat,
  output cdiv_state_e              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // in_ready is high only in IDLE and out_valid only in DONE, so operations never overlap;
  // the producer holds operands while in_valid is high, results hold until accepted.

  localparam int PW = 2 * DATA_W + 1;
  localparam int EW = PW + DATA_W;
  localparam int QW = DATA_W - 1;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 2);
  localparam logic signed [DATA_W-1:0] CLAMP_POS = {1'b0, {(DATA_W-1){1'b1}}};

  cdiv_state_e state_q, state_d;

  logic signed [DATA_W-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic [EW-1:0]            rem_r_q, rem_r_d, rem_i_q, rem_i_d, div_q, div_d;
  logic [QW-1:0]            q_r_q, q_r_d, q_i_q, q_i_d;
  logic                     neg_r_q, neg_r_d, neg_i_q, neg_i_d;
  logic                     ovf_r_q, ovf_r_d, ovf_i_q, ovf_i_d;
  logic                     dbz_q, dbz_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [DATA_W-1:0] yr_q, yr_d, yi_q, yi_d;
  logic                     div_by_zero_q, div_by_zero_d, sat_q, sat_d;

  // Full-precision products from the captured operands.
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] nr, ni;
  logic [PW-1:0]        den, mag_r, mag_i;
  logic [EW-1:0]        num_r_sh, num_i_sh, den_lim;

  assign ar_x  = PW'(ar_q);
  assign ai_x  = PW'(ai_q);
  assign br_x  = PW'(br_q);
  assign bi_x  = PW'(bi_q);
  assign nr    = ar_x * br_x + ai_x * bi_x;
  assign ni    = ai_x * br_x - ar_x * bi_x;
  assign den   = br_x * br_x + bi_x * bi_x;
  assign mag_r = nr[PW-1] ? -nr : nr;
  assign mag_i = ni[PW-1] ? -ni : ni;

  assign num_r_sh = EW'(mag_r) << FRAC_W;
  assign num_i_sh = EW'(mag_i) << FRAC_W;
  assign den_lim  = EW'(den) << (DATA_W - 1);

  logic [EW-1:0] step_rem_r, step_rem_i;
  logic          step_bit_r, step_bit_i;
  logic [QW-1:0] q_r_next, q_i_next;

  cdiv_mag_step #(.W(EW)) u_step_re (
    .rem_i   (rem_r_q),
    .div_i   (div_q),
    .rem_o   (step_rem_r),
    .q_bit_o (step_bit_r)
  );

  cdiv_mag_step #(.W(EW)) u_step_im (
    .rem_i   (rem_i_q),
    .div_i   (div_q),
    .rem_o   (step_rem_i),
    .q_bit_o (step_bit_i)
  );

  assign q_r_next = {q_r_q[QW-2:0], step_bit_r};
  assign q_i_next = {q_i_q[QW-2:0], step_bit_i};

  // Zero divisor wins over overflow; a zero magnitude gives +0 since -0 == 0.
  function automatic logic signed [DATA_W-1:0] finish_comp(
    input logic [QW-1:0] q,
    input logic          neg,
    input logic          ovf,
    input logic          dbz
  );
    logic signed [DATA_W-1:0] mag;
    mag = ovf ? CLAMP_POS : $signed({1'b0, q});
    if (dbz) return '0;
    return neg ? -mag : mag;
  endfunction

  always_comb begin
    state_d       = state_q;
    ar_d          = ar_q;
    ai_d          = ai_q;
    br_d          = br_q;
    bi_d          = bi_q;
    rem_r_d       = rem_r_q;
    rem_i_d       = rem_i_q;
    div_d         = div_q;
    q_r_d         = q_r_q;
    q_i_d         = q_i_q;
    neg_r_d       = neg_r_q;
    neg_i_d       = neg_i_q;
    ovf_r_d       = ovf_r_q;
    ovf_i_d       = ovf_i_q;
    dbz_d         = dbz_q;
    cnt_d         = cnt_q;
    yr_d          = yr_q;
    yi_d          = yi_q;
    div_by_zero_d = div_by_zero_q;
    sat_d         = sat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ar_d    = ar;
          ai_d    = ai;
          br_d    = br;
          bi_d    = bi;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        rem_r_d = num_r_sh;
        rem_i_d = num_i_sh;
        div_d   = EW'(den) << (DATA_W - 2);
        q_r_d   = '0;
        q_i_d   = '0;
        neg_r_d = nr[PW-1];
        neg_i_d = ni[PW-1];
        ovf_r_d = (num_r_sh >= den_lim);
        ovf_i_d = (num_i_sh >= den_lim);
        dbz_d   = (den == '0);
        cnt_d   = '0;
        state_d = ST_DIV;
      end
      ST_DIV: begin
        rem_r_d = step_rem_r;
        rem_i_d = step_rem_i;
        q_r_d   = q_r_next;
        q_i_d   = q_i_next;
        div_d   = div_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          yr_d          = finish_comp(q_r_next, neg_r_q, ovf_r_q, dbz_q);
          yi_d          = finish_comp(q_i_next, neg_i_q, ovf_i_q, dbz_q);
          div_by_zero_d = dbz_q;
          sat_d         = !dbz_q && (ovf_r_q || ovf_i_q);
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ar_q          <= '0;
      ai_q          <= '0;
      br_q          <= '0;
      bi_q          <= '0;
      rem_r_q       <= '0;
      rem_i_q       <= '0;
      div_q         <= '0;
      q_r_q         <= '0;
      q_i_q         <= '0;
      neg_r_q       <= 1'b0;
      neg_i_q       <= 1'b0;
      ovf_r_q       <= 1'b0;
      ovf_i_q       <= 1'b0;
      dbz_q         <= 1'b0;
      cnt_q         <= '0;
      yr_q          <= '0;
      yi_q          <= '0;
      div_by_zero_q <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ar_q          <= ar_d;
      ai_q          <= ai_d;
      br_q          <= br_d;
      bi_q          <= bi_d;
      rem_r_q       <= rem_r_d;
      rem_i_q       <= rem_i_d;
      div_q         <= div_d;
      q_r_q         <= q_r_d;
      q_i_q         <= q_i_d;
      neg_r_q       <= neg_r_d;
      neg_i_q       <= neg_i_d;
      ovf_r_q       <= ovf_r_d;
      ovf_i_q       <= ovf_i_d;
      dbz_q         <= dbz_d;
      cnt_q         <= cnt_d;
      yr_q          <= yr_d;
      yi_q          <= yi_d;
      div_by_zero_q <= div_by_zero_d;
      sat_q         <= sat_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign yr          = yr_q;
  assign yi          = yi_q;
  assign div_by_zero = div_by_zero_q;
  assign sat         = sat_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_complex_div.sv
// Directed bench for complex_div in Q2.14: hand-computed quotients, latency,
// backpressure and mid-operation reset.
module tb_complex_div;
  import complex_div_pkg::*;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 14;
  localparam int LAT    = DATA_W;
  localparam int TMO    = 60;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] ar = '0, ai = '0, br = '0, bi = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [DATA_W-1:0] yr, yi;
  logic                     div_by_zero, sat;
  cdiv_state_e              dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  complex_div #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ar          (ar),
    .ai          (ai),
    .br          (br),
    .bi          (bi),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .yr          (yr),
    .yi          (yi),
    .div_by_zero (div_by_zero),
    .sat         (sat),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operand set at a negedge and return once it has been accepted.
  task automatic send(input int a_r, input int a_i, input int b_r, input int b_i);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_send", in_ready, 1);
    ar = DATA_W'(a_r);
    ai = DATA_W'(a_i);
    br = DATA_W'(b_r);
    bi = DATA_W'(b_i);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid, bounded.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
  endtask

  task automatic expect_out(input string tag, input int e_yr, input int e_yi,
                            input int e_dbz, input int e_sat);
    check({tag, "_yr"}, yr, e_yr);
    check({tag, "_yi"}, yi, e_yi);
    check({tag, "_dbz"}, div_by_zero, e_dbz);
    check({tag, "_sat"}, sat, e_sat);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_done", in_ready, 1);
    check("out_valid_after_done", out_valid, 0);
  endtask

  task automatic run_op(input string tag, input int a_r, input int a_i, input int b_r,
                        input int b_i, input int e_yr, input int e_yi,
                        input int e_dbz, input int e_sat);
    send(a_r, a_i, b_r, b_i);
    wait_result(tag);
    expect_out(tag, e_yr, e_yi, e_dbz, e_sat);
    drain();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_yr", yr, 0);
    check("rst_yi", yi, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_sat", sat, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: a, b, expected y, dbz, sat
    run_op("one_div_one",   16384, 0,     16384, 0,     16384, 0,      0, 0);
    run_op("div_by_j",      8192,  8192,  0,     16384, 8192,  -8192,  0, 0);
    run_op("ovf_pos",       16384, 0,     4096,  0,     32767, 0,      0, 1);
    run_op("ovf_neg",       -16384, 0,    4096,  0,     -32767, 0,     0, 1);
    run_op("zero_div",      1000,  -2000, 0,     0,     0,     0,      1, 0);
    run_op("trunc_pos",     16384, 0,     12288, 0,     21845, 0,      0, 0);
    run_op("trunc_neg",     -16384, 0,    12288, 0,     -21845, 0,     0, 0);
    run_op("diag",          16384, 16384, 16384, 16384, 16384, 0,      0, 0);
    run_op("imag_only",     0,     8192,  16384, 0,     0,     8192,   0, 0);
    run_op("extreme",       -32768, -32768, -32768, -32768, 16384, 0,  0, 0);
    run_op("zero_num",      0,     0,     100,   -200,  0,     0,      0, 0);

    // Backpressure in DONE: results hold, in_valid pulses are ignored
    send(8192, 8192, 0, 16384);
    wait_result("bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ar = DATA_W'($urandom_range(0, 16383));
      ai = DATA_W'($urandom_range(0, 16383));
      br = DATA_W'($urandom_range(1, 16383));
      bi = DATA_W'($urandom_range(0, 16383));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_yr", yr, 8192);
      check("bp_yi", yi, -8192);
      check("bp_state", dbg_state, ST_DONE);
    end
    drain();
    // Nothing was captured during backpressure, so the block stays idle.
    repeat (3) @(posedge clk);
    #1;
    check("bp_idle_after", dbg_state, ST_IDLE);
    check("bp_no_result", out_valid, 0);
    run_op("after_bp",      16384, 0,     16384, 0,     16384, 0,      0, 0);

    // Reset pulsed at DIV cycle 5 abandons the operation
    send(16384, 0, 4096, 0);
    repeat (6) @(posedge clk);
    #1;
    check("mid_state_div", dbg_state, ST_DIV);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_yr", yr, 0);
    check("mid_rst_sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 2 * LAT; k++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      check("mid_rst_no_result", seen, 0);
    end
    run_op("after_rst",     0,     16384, 0,     16384, 16384, 0,      0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
